tt_um_mux_selctl_bmsce: RTL and testbench

Select-control front end for the 2:1 multiplexer tile. It synchronises the raw pad inputs, debounces a push-button select, and optionally generates an automatic periodic select. It drives the registered 2:1 mux output plus status onto the dedicated outputs. It sits directly upstream of, and wraps, the combinational mux datapath, replacing the raw `ui_in[0]` select with a clean, stateful select.

---
 rtl/tt_um_mux_selctl_bmsce.sv | 142 ++++++++++++++
 tb/tb_tt_um_mux_selctl_bmsce.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/tt_um_mux_selctl_bmsce.sv
// tt_um_mux_selctl_bmsce
// Select-control front end for the 2:1 mux tile. It synchronises the pad
// inputs and debounces the select button. In auto mode it generates a
// periodic select instead. It drives the registered mux output and status.
// Build option: define MUXSEL_DEBOUNCE_EN to enable the counted debounce.
// When it is undefined, the debounced level is simply the synchronised level
// from the previous cycle.
module tt_um_mux_selctl_bmsce #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int AUTO_PERIOD     = 256
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int PW = $clog2(AUTO_PERIOD);
    localparam logic [PW-1:0] P_LAST = PW'(AUTO_PERIOD - 1);

    // Reject illegal parameterisations at elaboration time.
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_db
        $error("DEBOUNCE_CYCLES out of range 1..65535");
    end
    if (AUTO_PERIOD < 2 || AUTO_PERIOD > 65536) begin : g_bad_period
        $error("AUTO_PERIOD out of range 2..65536");
    end

    logic [3:0]    s1;
    logic [3:0]    s2;
    logic          btn_s;
    logic          in1_s;
    logic          in2_s;
    logic          mode_s;
    logic          mode_prev;
    logic          mode_chg;
    logic          db_level;
    logic          press;
    logic          toggle;
    logic          sel;
    logic          y;
    logic [3:0]    toggle_cnt;
    logic [PW-1:0] pcnt;

    assign btn_s  = s2[0];
    assign in1_s  = s2[1];
    assign in2_s  = s2[2];
    assign mode_s = s2[3];

    // Two-flop synchroniser for button, both data inputs and mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= ui_in[3:0];
            s2 <= s1;
        end
    end

`ifdef MUXSEL_DEBOUNCE_EN
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic [DW-1:0] db_cnt;

    // A press is the edge where a rising button level is finally accepted.
    always_comb begin
        press = btn_s & ~db_level & (db_cnt == DB_LAST);
    end

    // Count consecutive cycles that disagree with the accepted level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt   <= '0;
            db_level <= 1'b0;
        end else if (btn_s == db_level) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            db_level <= btn_s;
            db_cnt   <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end
`else
    // Without debounce, any synchronised rising level counts as a press.
    always_comb begin
        press = btn_s & ~db_level;
    end

    // The accepted level just follows the synchronised button.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_level <= 1'b0;
        end else begin
            db_level <= btn_s;
        end
    end
`endif

    // A mode change suppresses toggling for one edge while the period restarts.
    always_comb begin
        mode_chg = mode_s ^ mode_prev;
        toggle   = ~mode_chg & (mode_s ? (pcnt == P_LAST) : press);
    end

    // Period counter, select state, toggle counter and the registered mux.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_prev  <= 1'b0;
            pcnt       <= '0;
            sel        <= 1'b0;
            y          <= 1'b0;
            toggle_cnt <= '0;
        end else begin
            mode_prev <= mode_s;
            y         <= sel ? in2_s : in1_s;
            if (mode_chg || !mode_s || pcnt == P_LAST) begin
                pcnt <= '0;
            end else begin
                pcnt <= pcnt + 1'b1;
            end
            if (toggle) begin
                sel        <= ~sel;
                toggle_cnt <= toggle_cnt + 1'b1;
            end
        end
    end

    assign uo_out  = {toggle_cnt, in2_s, in1_s, sel, y};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

    logic unused_ok;
    assign unused_ok = &{1'b0, ena, uio_in, ui_in[7:4]};

endmodule

// File: tb/tb_tt_um_mux_selctl_bmsce.sv
// Testbench for tt_um_mux_selctl_bmsce: random and directed stimulus checked
// against a cycle-level behavioural model of the select rules.
module tb_tt_um_mux_selctl_bmsce;

    localparam int DB = 16;
    localparam int AP = 256;
`ifdef MUXSEL_DEBOUNCE_EN
    localparam int D_EFF = DB;
`else
    localparam int D_EFF = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_chk = 0;
    int n_pass = 0;

    tt_um_mux_selctl_bmsce #(.DEBOUNCE_CYCLES(DB), .AUTO_PERIOD(AP)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in),
        .uo_out(uo_out), .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Behavioural model: pad values delayed two cycles, a run length of
    // cycles disagreeing with the accepted button level, edges since the
    // period restart, and the select/toggle count state.
    logic [3:0] m_d1, m_d2;
    logic       m_level, m_mode_prev, m_sel, m_y;
    int         m_run, m_since, m_cnt;

    task automatic m_reset();
        m_d1 = '0; m_d2 = '0; m_level = 0; m_mode_prev = 0;
        m_sel = 0; m_y = 0; m_run = 0; m_since = 0; m_cnt = 0;
    endtask

    task automatic model_edge(input logic [7:0] ui);
        logic btn, mode, chg, press, hit, tog;
        btn = m_d2[0];
        mode = m_d2[3];
        press = 0;
        if (btn != m_level) begin
            m_run++;
            if (m_run >= D_EFF) begin
                m_level = btn;
                press = btn;
                m_run = 0;
            end
        end else begin
            m_run = 0;
        end
        chg = (mode != m_mode_prev);
        m_mode_prev = mode;
        hit = 0;
        if (chg || !mode) m_since = 0;
        else begin
            m_since++;
            if (m_since == AP) begin
                hit = 1;
                m_since = 0;
            end
        end
        tog = !chg && (mode ? hit : press);
        m_y = m_sel ? m_d2[2] : m_d2[1];
        if (tog) begin
            m_sel = !m_sel;
            m_cnt = (m_cnt + 1) % 16;
        end
        m_d2 = m_d1;
        m_d1 = ui[3:0];
    endtask

    function automatic logic [7:0] m_out();
        logic [3:0] c;
        c = 4'(m_cnt);
        return {c, m_d2[2], m_d2[1], m_sel, m_y};
    endfunction

    // Drive inputs at a negedge, advance one rising edge, compare at the next negedge.
    task automatic step(input logic [7:0] ui);
        ui_in = ui;
        model_edge(ui);
        @(posedge clk);
        @(negedge clk);
        check("uo_out", uo_out, m_out());
    endtask

    initial begin
        int rise_edge, first_tog, n_tog;
        logic prev_sel, mode, lvl;
        int len;

        // Reset held with all inputs high
        m_reset();
        ui_in = 8'hFF;
        repeat (3) begin
            @(negedge clk);
            check("rst_uo", uo_out, 8'h00);
            check("rst_uio_oe", uio_oe, 8'h00);
            check("rst_uio_out", uio_out, 8'h00);
        end
        ui_in = 8'h00;
        rst_n = 1'b1;
        repeat (3) begin
            step(8'h00);
            check("post_rst", uo_out, 8'h00);
        end

        // Data path with sel=0
        step(8'h02);
        check("data_e1", {15'd0, uo_out[0]}, 16'd0);
        step(8'h02);
        check("data_e2", {15'd0, uo_out[0]}, 16'd0);
        step(8'h02);
        check("data_e3", {12'd0, uo_out[3:0]}, 16'h5);

        // Manual press held: measure the edge at which sel rises
        rise_edge = 0;
        for (int e = 1; e <= 40; e++) begin
            step(8'h05);
            if (rise_edge == 0 && uo_out[1]) rise_edge = e;
            if (e == 2 + D_EFF + 1) check("y_in2", {15'd0, uo_out[0]}, 16'd1);
        end
        check("press_edge", 16'(rise_edge), 16'(2 + D_EFF));
        check("press_cnt", {12'd0, uo_out[7:4]}, 16'd1);
        repeat (30) step(8'h04);
        // Short pulse: rejected with debounce, accepted without
        repeat (10) step(8'h05);
        repeat (30) step(8'h04);
        check("pulse10_cnt", {12'd0, uo_out[7:4]}, (D_EFF > 10) ? 16'd1 : 16'd2);

        // Auto mode with random button and data activity
        prev_sel = uo_out[1];
        first_tog = 0;
        n_tog = 0;
        for (int e = 1; e <= 800; e++) begin
            step({4'($urandom_range(0, 15)), 1'b1, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1))});
            if (uo_out[1] != prev_sel) begin
                n_tog++;
                if (first_tog == 0) first_tog = e;
            end
            prev_sel = uo_out[1];
        end
        check("auto_ntog", 16'(n_tog), 16'd3);
        check("auto_first", 16'(first_tog), 16'(3 + AP));

        // Random mixed manual/auto segments with held button levels
        for (int seg = 0; seg < 10; seg++) begin
            mode = 1'($urandom_range(0, 1));
            for (int r = 0; r < 10; r++) begin
                lvl = 1'($urandom_range(0, 1));
                len = $urandom_range(1, 30);
                for (int i = 0; i < len; i++)
                    step({4'($urandom_range(0, 15)), mode, 2'($urandom_range(0, 3)), lvl});
            end
        end

        // Asynchronous reset partway through an auto period
        repeat (300) step(8'h08);
        #2 rst_n = 1'b0;
        #1 check("async_rst", uo_out, 8'h00);
        @(negedge clk);
        check("async_rst_hold", uo_out, 8'h00);
        m_reset();
        ui_in = 8'h00;
        rst_n = 1'b1;
        repeat (3) step(8'h00);

        // Sixteen accepted presses wrap the toggle counter
        for (int p = 1; p <= 16; p++) begin
            repeat (20) step(8'h01);
            repeat (20) step(8'h00);
            if (p == 8) check("wrap_mid", {12'd0, uo_out[7:4]}, 16'd8);
        end
        check("wrap_cnt", {12'd0, uo_out[7:4]}, 16'd0);
        check("wrap_sel", {15'd0, uo_out[1]}, 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
